// File: rtl/nasti_stream_transposer.sv
`default_nettype none
// ============================================================================
//  Module   : nasti_stream_transposer
//  Purpose  : Turns each NxN element block received as N row beats into N
//             column beats. Two banks alternate so that one block fills while
//             the other drains, giving one beat per cycle in each direction.
//  Revision : 1.0  initial release
// ============================================================================
module nasti_stream_transposer #(
  parameter int DATA_WIDTH = 64,
  parameter int ELEM_WIDTH = 8,
  parameter int DEST_WIDTH = 3,
  parameter int USER_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  // row stream in
  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic                    src_t_last,
  input  logic [DEST_WIDTH-1:0]   src_t_dest,
  input  logic [USER_WIDTH-1:0]   src_t_user,
  input  logic [(DATA_WIDTH+7)/8-1:0] src_t_keep,
  input  logic [(DATA_WIDTH+7)/8-1:0] src_t_strb,
  // column stream out
  output logic                    dest_t_valid,
  input  logic                    dest_t_ready,
  output logic [DATA_WIDTH-1:0]   dest_t_data,
  output logic                    dest_t_last,
  output logic [DEST_WIDTH-1:0]   dest_t_dest,
  output logic [USER_WIDTH-1:0]   dest_t_user,
  output logic [(DATA_WIDTH+7)/8-1:0] dest_t_keep,
  output logic [(DATA_WIDTH+7)/8-1:0] dest_t_strb,
  // status
  output logic                    err_short,
  output logic [15:0]             blk_count
);

  localparam int N  = DATA_WIDTH / ELEM_WIDTH;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

  // Reject parameter sets the datapath cannot represent.
  if (DATA_WIDTH % ELEM_WIDTH != 0) begin : g_chk_div
    $error("DATA_WIDTH must be a multiple of ELEM_WIDTH");
  end
  if ((N < 1) || ((N & (N - 1)) != 0)) begin : g_chk_pow2
    $error("DATA_WIDTH/ELEM_WIDTH must be a power of 2");
  end
  if (USER_WIDTH < DEST_WIDTH) begin : g_chk_user
    $error("USER_WIDTH must be >= DEST_WIDTH");
  end

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  bank_state_e            state_q [2];
  bank_state_e            state_d [2];
  logic [N-1:0]           mask_q  [2];   // rows actually written in this block
  logic [N-1:0]           mask_d  [2];
  logic [USER_WIDTH-1:0]  meta_q  [2];   // t_user captured from row 0
  logic [USER_WIDTH-1:0]  meta_d  [2];
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [RW-1:0]          wr_row_q, wr_row_d;
  logic [RW-1:0]          rd_col_q, rd_col_d;
  logic                   err_short_q, err_short_d;
  logic [15:0]            blk_count_q, blk_count_d;
  logic [DATA_WIDTH-1:0]  mem_q [2][N];
  logic [DATA_WIDTH-1:0]  col_data;
  logic                   accept;
  logic                   rd_xfer;
  logic                   unused_inputs;

  // Sideband the block does not consume: keep/strb are ignored, the input
  // t_dest is replaced by the issuer-chosen hop carried in t_user.
  assign unused_inputs = ^{src_t_keep, src_t_strb, src_t_dest};

  assign src_t_ready  = !areset && (state_q[wr_bank_q] != BANK_FULL);
  assign dest_t_valid = (state_q[rd_bank_q] == BANK_FULL);
  assign accept       = src_t_valid && src_t_ready;
  assign rd_xfer      = dest_t_valid && dest_t_ready;

  assign dest_t_data  = col_data;
  assign dest_t_last  = (rd_col_q == LAST_IDX);
  assign dest_t_user  = meta_q[rd_bank_q];
  assign dest_t_dest  = meta_q[rd_bank_q][DEST_WIDTH-1:0];
  assign dest_t_keep  = '1;
  assign dest_t_strb  = '1;
  assign err_short    = err_short_q;
  assign blk_count    = blk_count_q;

  // Next-state for bank states, pointers, row masks and status counters.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    meta_d      = meta_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    rd_col_d    = rd_col_q;
    err_short_d = err_short_q;
    blk_count_d = blk_count_q;

    // Write and read always address different banks (one is FULL, the
    // other is not), so both updates can be applied in the same cycle.
    if (accept) begin
      if (wr_row_q == '0) begin
        meta_d[wr_bank_q]  = src_t_user;
        mask_d[wr_bank_q]  = '0;
        state_d[wr_bank_q] = BANK_FILLING;
      end
      mask_d[wr_bank_q][wr_row_q] = 1'b1;
      if ((wr_row_q == LAST_IDX) || src_t_last) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
        wr_row_d           = '0;
        if (wr_row_q != LAST_IDX) begin
          err_short_d = 1'b1;
        end
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    if (rd_xfer) begin
      if (rd_col_q == LAST_IDX) begin
        state_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d          = ~rd_bank_q;
        rd_col_d           = '0;
        blk_count_d        = blk_count_q + 16'd1;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  // Control state register; reset discards any partial block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        mask_q[b]  <= '0;
        meta_q[b]  <= '0;
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
      err_short_q <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      meta_q      <= meta_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      rd_col_q    <= rd_col_d;
      err_short_q <= err_short_d;
      blk_count_q <= blk_count_d;
    end
  end

  // Row storage; not cleared on reset since the row mask hides stale rows.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wr_bank_q][wr_row_q] <= src_t_data;
    end
  end

  // Gather column rd_col from every row; rows missing from a short block read as zero.
  always_comb begin
    col_data = '0;
    for (int k = 0; k < N; k++) begin
      if (mask_q[rd_bank_q][k]) begin
        col_data[k*ELEM_WIDTH +: ELEM_WIDTH] =
          mem_q[rd_bank_q][k][rd_col_q*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_transposer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nasti_stream_transposer
//  Purpose  : Self-checking bench for nasti_stream_transposer (8x8 bytes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_nasti_stream_transposer;

  typedef logic [63:0] rows_t [8];
  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  dst;
    logic [7:0]  user;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        src_t_valid = 1'b0;
  logic        src_t_ready;
  logic [63:0] src_t_data = '0;
  logic        src_t_last = 1'b0;
  logic [2:0]  src_t_dest = '0;
  logic [7:0]  src_t_user = '0;
  logic [7:0]  src_t_keep = '1;
  logic [7:0]  src_t_strb = '1;
  logic        dest_t_valid;
  logic        dest_t_ready = 1'b1;
  logic [63:0] dest_t_data;
  logic        dest_t_last;
  logic [2:0]  dest_t_dest;
  logic [7:0]  dest_t_user;
  logic [7:0]  dest_t_keep;
  logic [7:0]  dest_t_strb;
  logic        err_short;
  logic [15:0] blk_count;

  int     n_cmp = 0;
  int     n_fail = 0;
  int     acc_cnt = 0;
  int     stall_cnt = 0;
  longint cyc = 0;
  beat_t  exp_q[$];
  beat_t  got_q[$];
  longint got_cyc[$];
  longint acc_cyc[$];

  nasti_stream_transposer dut (
    .aclk(aclk), .areset(areset),
    .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
    .src_t_last(src_t_last), .src_t_dest(src_t_dest), .src_t_user(src_t_user),
    .src_t_keep(src_t_keep), .src_t_strb(src_t_strb),
    .dest_t_valid(dest_t_valid), .dest_t_ready(dest_t_ready), .dest_t_data(dest_t_data),
    .dest_t_last(dest_t_last), .dest_t_dest(dest_t_dest), .dest_t_user(dest_t_user),
    .dest_t_keep(dest_t_keep), .dest_t_strb(dest_t_strb),
    .err_short(err_short), .blk_count(blk_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Record transfers mid-cycle, where all DUT outputs are settled.
  always @(negedge aclk) begin
    if (!areset && dest_t_valid && dest_t_ready) begin
      got_q.push_back({dest_t_data, dest_t_last, dest_t_dest, dest_t_user});
      got_cyc.push_back(cyc);
    end
    if (src_t_valid && src_t_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc.push_back(cyc);
    end
    if (!areset && src_t_valid && !src_t_ready) stall_cnt <= stall_cnt + 1;
  end

  // Reference: column c holds element c of each received row, zero for rows never sent.
  function automatic void model_block(input rows_t rows, input int nrows, input logic [7:0] user);
    for (int c = 0; c < 8; c++) begin
      beat_t b;
      b.data = '0;
      for (int k = 0; k < nrows; k++) b.data[k*8 +: 8] = rows[k][c*8 +: 8];
      b.last = (c == 7);
      b.dst  = user[2:0];
      b.user = user;
      exp_q.push_back(b);
    end
  endfunction

  function automatic void rand_rows(output rows_t rows);
    for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
  endfunction

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); got_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic last,
                            input logic [7:0] user, input logic [2:0] dst);
    bit acc = 1'b0;
    src_t_valid = 1'b1; src_t_data = d; src_t_last = last;
    src_t_user = user; src_t_dest = dst;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      acc = src_t_ready;
      @(posedge aclk); #1;
      if (acc) break;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL src_accept_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic idle();
    src_t_valid = 1'b0; src_t_last = 1'b0;
  endtask

  task automatic drive_block(input rows_t rows, input int nrows, input logic [7:0] user,
                             input logic [2:0] dst, input bit last_at_end, input bit gaps);
    for (int r = 0; r < nrows; r++) begin
      logic lst;
      lst = (r == nrows - 1) ? ((nrows < 8) ? 1'b1 : last_at_end) : 1'b0;
      drive_beat(rows[r], lst, (r == 0) ? user : 8'($urandom),
                 (r == 0) ? dst : 3'($urandom));
      if (gaps && ($urandom % 3 == 0)) begin
        idle(); @(posedge aclk); #1;
      end
    end
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 3000 && got_q.size() < n; i++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    n_cmp++; if (src_t_ready !== 1'b0) begin n_fail++; $display("FAIL rst_src_ready got=%b exp=0", src_t_ready); end
    n_cmp++; if (dest_t_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dest_valid got=%b exp=0", dest_t_valid); end
    n_cmp++; if (err_short !== 1'b0) begin n_fail++; $display("FAIL rst_err_short got=%b exp=0", err_short); end
    n_cmp++; if (blk_count !== 16'd0) begin n_fail++; $display("FAIL rst_blk_count got=%0d exp=0", blk_count); end
    areset = 1'b0;
    @(posedge aclk); #1;
    n_cmp++; if (src_t_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_src_ready got=%b exp=1", src_t_ready); end
    n_cmp++; if ({dest_t_keep, dest_t_strb} !== 16'hFFFF) begin n_fail++; $display("FAIL keep_strb got=%h exp=ffff", {dest_t_keep, dest_t_strb}); end
  endtask

  task automatic test_transpose_pattern();
    rows_t rows;
    logic [7:0] u;
    clear_sb();
    u = 8'($urandom);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) rows[r][c*8 +: 8] = 8'(r * 8 + c);
    model_block(rows, 8, u);
    drive_block(rows, 8, u, 3'($urandom), 1'b1, 1'b0);
    idle();
    wait_got(8);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pat_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL pat_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    if (got_q.size() == 8) begin
      n_cmp++; if (got_q[0].data !== 64'h3830282018100800) begin n_fail++; $display("FAIL pat_beat0_const got=%h exp=3830282018100800", got_q[0].data); end
      n_cmp++; if (got_q[7].data !== 64'h3F372F271F170F07) begin n_fail++; $display("FAIL pat_beat7_const got=%h exp=3f372f271f170f07", got_q[7].data); end
    end
    n_cmp++; if (blk_count !== 16'd1) begin n_fail++; $display("FAIL pat_blk_count got=%0d exp=1", blk_count); end
  endtask

  task automatic test_user_dest();
    rows_t rows;
    clear_sb();
    rand_rows(rows);
    model_block(rows, 8, 8'h05);
    drive_block(rows, 8, 8'h05, 3'h2, 1'b1, 1'b0);
    idle();
    wait_got(8);
    n_cmp++; if (got_q.size() != 8) begin n_fail++; $display("FAIL ud_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ud_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].dst !== 3'd5 || got_q[i].user !== 8'h05) begin
        n_fail++; $display("FAIL ud_side%0d got=%0d/%h exp=5/05", i, got_q[i].dst, got_q[i].user);
      end
    end
  endtask

  task automatic test_back_to_back();
    rows_t rows;
    logic [7:0] u;
    logic [15:0] base;
    int stall0;
    clear_sb();
    base = blk_count;
    stall0 = stall_cnt;
    for (int b = 0; b < 4; b++) begin
      rand_rows(rows);
      u = 8'($urandom);
      model_block(rows, 8, u);
      drive_block(rows, 8, u, 3'($urandom), 1'b1, 1'b0);
    end
    idle();
    wait_got(32);
    n_cmp++; if (got_q.size() != 32) begin n_fail++; $display("FAIL b2b_count got=%0d exp=32", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    if (got_cyc.size() == 32 && acc_cyc.size() >= 8) begin
      n_cmp++; if (got_cyc[0] != acc_cyc[7] + 1) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", got_cyc[0], acc_cyc[7] + 1); end
      n_cmp++; if (got_cyc[31] - got_cyc[0] != 31) begin n_fail++; $display("FAIL b2b_contiguous got=%0d exp=31", got_cyc[31] - got_cyc[0]); end
    end
    n_cmp++; if (stall_cnt != stall0) begin n_fail++; $display("FAIL b2b_src_stall got=%0d exp=0", stall_cnt - stall0); end
    n_cmp++; if (blk_count !== 16'(base + 16'd4)) begin n_fail++; $display("FAIL b2b_blk_count got=%0d exp=%0d", blk_count, base + 16'd4); end
  endtask

  task automatic test_backpressure();
    rows_t rows;
    logic [7:0] u;
    int a0;
    clear_sb();
    dest_t_ready = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        for (int b = 0; b < 3; b++) begin
          rand_rows(rows);
          u = 8'($urandom);
          model_block(rows, 8, u);
          drive_block(rows, 8, u, 3'($urandom), 1'b1, 1'b0);
        end
        idle();
      end
      begin
        for (int i = 0; i < 300 && (acc_cnt - a0) < 16; i++) @(posedge aclk);
        repeat (10) @(posedge aclk);
        #2;
        n_cmp++; if (acc_cnt - a0 != 16) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=16", acc_cnt - a0); end
        n_cmp++; if (src_t_ready !== 1'b0) begin n_fail++; $display("FAIL bp_src_ready got=%b exp=0", src_t_ready); end
        dest_t_ready = 1'b1;
      end
    join
    wait_got(24);
    n_cmp++; if (got_q.size() != 24) begin n_fail++; $display("FAIL bp_count got=%0d exp=24", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_short_block();
    rows_t rows;
    logic [7:0] u;
    clear_sb();
    n_cmp++; if (err_short !== 1'b0) begin n_fail++; $display("FAIL short_err_before got=%b exp=0", err_short); end
    rand_rows(rows);
    u = 8'($urandom);
    model_block(rows, 4, u);
    drive_block(rows, 4, u, 3'($urandom), 1'b1, 1'b0);
    rand_rows(rows);
    u = 8'($urandom);
    model_block(rows, 8, u);
    drive_block(rows, 8, u, 3'($urandom), 1'b1, 1'b0);
    idle();
    wait_got(16);
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL short_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL short_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0].data[63:32] !== 32'h0) begin n_fail++; $display("FAIL short_zero_fill got=%h exp=0", got_q[0].data[63:32]); end
    end
    n_cmp++; if (err_short !== 1'b1) begin n_fail++; $display("FAIL short_err_after got=%b exp=1", err_short); end
  endtask

  task automatic test_random();
    rows_t rows;
    logic [7:0] u;
    int nr;
    bit done;
    clear_sb();
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          rand_rows(rows);
          u = 8'($urandom);
          nr = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : 8;
          model_block(rows, nr, u);
          drive_block(rows, nr, u, 3'($urandom), 1'($urandom), 1'b1);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #2;
          dest_t_ready = ($urandom % 3 != 0);
        end
        dest_t_ready = 1'b1;
      end
    join
    wait_got(exp_q.size());
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++; if (err_short !== 1'b1) begin n_fail++; $display("FAIL rnd_err_sticky got=%b exp=1", err_short); end
  endtask

  task automatic test_reset_midblock();
    rows_t rows;
    logic [7:0] u;
    clear_sb();
    dest_t_ready = 1'b0;
    rand_rows(rows);
    drive_block(rows, 8, 8'($urandom), 3'($urandom), 1'b1, 1'b0);
    rand_rows(rows);
    for (int r = 0; r < 5; r++) drive_beat(rows[r], 1'b0, 8'($urandom), 3'($urandom));
    idle();
    #2;
    areset = 1'b1;
    #1;
    n_cmp++; if (dest_t_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_dest_valid got=%b exp=0", dest_t_valid); end
    n_cmp++; if (src_t_ready !== 1'b0) begin n_fail++; $display("FAIL mrst_src_ready got=%b exp=0", src_t_ready); end
    n_cmp++; if (err_short !== 1'b0) begin n_fail++; $display("FAIL mrst_err_short got=%b exp=0", err_short); end
    n_cmp++; if (blk_count !== 16'd0) begin n_fail++; $display("FAIL mrst_blk_count got=%0d exp=0", blk_count); end
    @(posedge aclk); #1;
    areset = 1'b0;
    clear_sb();
    dest_t_ready = 1'b1;
    rand_rows(rows);
    u = 8'($urandom);
    model_block(rows, 8, u);
    drive_block(rows, 8, u, 3'($urandom), 1'b1, 1'b0);
    rand_rows(rows);
    u = 8'($urandom);
    model_block(rows, 2, u);
    drive_block(rows, 2, u, 3'($urandom), 1'b1, 1'b0);
    idle();
    wait_got(16);
    n_cmp++; if (got_q.size() != 16) begin n_fail++; $display("FAIL mrst_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mrst_beat%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++; if (blk_count !== 16'd2) begin n_fail++; $display("FAIL mrst_blk_after got=%0d exp=2", blk_count); end
  endtask

  initial begin
    test_reset();
    test_transpose_pattern();
    test_user_dest();
    test_back_to_back();
    test_backpressure();
    test_short_block();
    test_random();
    test_reset_midblock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
